// File: rtl/pwm_hue_sequencer_pkg.sv
// Shared PWM definitions: sector type, hue wheel size and the duty width helper
// used by the sequencer and by the pwm channel instances.
package pwm_pkg;

  typedef logic [2:0] sector_t;

  localparam int unsigned NUM_SECTORS = 6;

  function automatic int unsigned duty_w(input int unsigned interval);
    return $clog2(interval);
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter; period_tick marks the last clock of each period
// so consumers can update registers exactly on the period boundary.
module pwm_period_timer #(
  parameter int unsigned PWM_INTERVAL = 12000
) (
  input  logic clk,
  input  logic rst_n,
  output logic period_tick
);

  localparam int unsigned CW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
  localparam logic [CW-1:0] PCNT_LAST = CW'(PWM_INTERVAL - 1);

  logic [CW-1:0] pcnt_q, pcnt_d;

  always_comb begin
    pcnt_d = pcnt_q + 1'b1;
    if (pcnt_q == PCNT_LAST) begin
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign period_tick = (pcnt_q == PCNT_LAST);

endmodule

// File: rtl/pwm_hue_sequencer.sv
// Walks R/G/B duties around a six-sector hue wheel, updating duties and hue
// state only on PWM period boundaries so no channel emits a truncated pulse.
module pwm_hue_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = 12000,
  parameter int unsigned STEP_PERIODS = 10,
  parameter int unsigned STEP_SIZE    = 100,
  localparam int unsigned DW          = duty_w(PWM_INTERVAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          restart,
  output logic [DW-1:0] red_duty,
  output logic [DW-1:0] green_duty,
  output logic [DW-1:0] blue_duty,
  output logic [2:0]    sector,
  output logic          period_tick,
  output logic          wrap
);

  localparam int unsigned SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [DW-1:0] FULL     = DW'(PWM_INTERVAL - 1);
  localparam logic [DW:0]   STEP     = (DW + 1)'(STEP_SIZE);
  localparam logic [SW-1:0] SCNT_LAST = SW'(STEP_PERIODS - 1);
  localparam sector_t       SEC_LAST = sector_t'(NUM_SECTORS - 1);

  sector_t       sector_q, sector_d;
  logic [DW-1:0] ramp_q, ramp_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          pend_q, pend_d;
  logic          wrap_q, wrap_d;
  logic [DW-1:0] red_q, red_d;
  logic [DW-1:0] green_q, green_d;
  logic [DW-1:0] blue_q, blue_d;

  logic [DW-1:0] map_r, map_g, map_b;
  logic [DW:0]   ramp_sum;
  logic [DW-1:0] ramp_sat;

  pwm_period_timer #(
    .PWM_INTERVAL(PWM_INTERVAL)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .period_tick(period_tick)
  );

  // One extra bit keeps ramp + STEP from wrapping before the clamp to FULL.
  assign ramp_sum = {1'b0, ramp_q} + STEP;
  assign ramp_sat = (ramp_sum > {1'b0, FULL}) ? FULL : ramp_sum[DW-1:0];

  always_comb begin
    map_r = '0;
    map_g = '0;
    map_b = '0;
    case (sector_q)
      3'd0: begin
        map_r = FULL;
        map_g = ramp_q;
      end
      3'd1: begin
        map_r = FULL - ramp_q;
        map_g = FULL;
      end
      3'd2: begin
        map_g = FULL;
        map_b = ramp_q;
      end
      3'd3: begin
        map_g = FULL - ramp_q;
        map_b = FULL;
      end
      3'd4: begin
        map_r = ramp_q;
        map_b = FULL;
      end
      3'd5: begin
        map_r = FULL;
        map_b = FULL - ramp_q;
      end
      default: begin
        map_r = FULL;
      end
    endcase
  end

  always_comb begin
    sector_d = sector_q;
    ramp_d   = ramp_q;
    scnt_d   = scnt_q;
    pend_d   = pend_q | restart;
    wrap_d   = 1'b0;
    red_d    = red_q;
    green_d  = green_q;
    blue_d   = blue_q;

    if (period_tick) begin
      // Duties reflect the state held through the period that is ending.
      red_d   = map_r;
      green_d = map_g;
      blue_d  = map_b;
      pend_d  = 1'b0;
      if (pend_q || restart) begin
        sector_d = '0;
        ramp_d   = '0;
        scnt_d   = '0;
      end else if (enable) begin
        if (scnt_q == SCNT_LAST) begin
          scnt_d = '0;
          if (ramp_q == FULL) begin
            ramp_d = '0;
            if (sector_q == SEC_LAST) begin
              sector_d = '0;
              wrap_d   = 1'b1;
            end else begin
              sector_d = sector_q + 3'd1;
            end
          end else begin
            ramp_d = ramp_sat;
          end
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sector_q <= '0;
      ramp_q   <= '0;
      scnt_q   <= '0;
      pend_q   <= 1'b0;
      wrap_q   <= 1'b0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
    end else begin
      sector_q <= sector_d;
      ramp_q   <= ramp_d;
      scnt_q   <= scnt_d;
      pend_q   <= pend_d;
      wrap_q   <= wrap_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
    end
  end

  assign red_duty   = red_q;
  assign green_duty = green_q;
  assign blue_duty  = blue_q;
  assign sector     = sector_q;
  assign wrap       = wrap_q;

endmodule
